razor_pipe_reg: RTL and testbench
=================================

Name: razor_pipe_reg

Overview:
Parametrised Razor-style pipeline stage register, the successor to the fixed two-field 32-bit IF/ID register.
- Holds WIDTH bits plus a valid bit.
- Checks each captured word against a late-sampled shadow copy one cycle later.
- On mismatch, corrects the main register from the shadow value, pulses an error, and stalls upstream for a programmable recovery window.
- Instantiated between any two CPU stages; the error/stall outputs feed the hazard unit.

Parameters:
WIDTH, 64, data bits held (e.g. pc concatenated with instr); ≥1
RECOVER_CYCLES, 1, cycles stall_out stays high after a detected error; ≥1
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
stall_in  input  1  downstream stall: hold contents
flush_in  input  1  insert bubble
valid_in  input  1  incoming word valid
d_in  input  WIDTH  incoming word
d_late  input  WIDTH  late-sampled copy of the word captured on the previous edge
valid_out  output  1  held word valid
q_out  output  WIDTH  held word
error_out  output  1  registered one-cycle error pulse
stall_out  output  1  recovery stall to upstream stages
err_count  output  CNT_W  saturating count of corrected errors

Behaviour:
- Reset (sync, wins over everything):
  - q_out=0, valid_out=0, error_out=0, stall_out=0, err_count=0.
  - chk_pending=0, FSM=NORMAL, recovery counter=0.
- FSM states: NORMAL, RECOVER.
- Internal chk_pending: set on any edge where d_in is loaded; cleared otherwise.
- Mismatch (combinational): mis = chk_pending & valid_out & (d_late != q_out).
- NORMAL, priority per edge: flush_in > mis > stall_in > load.
  - flush_in:
    - q_out<=0, valid_out<=0, chk_pending<=0.
    - Any concurrent mis is discarded: no error_out, no count.
  - mis:
    - q_out<=d_late; valid_out unchanged.
    - error_out<=1; stall_out<=1; counter<=RECOVER_CYCLES.
    - FSM<=RECOVER; chk_pending<=0.
    - stall_in is ignored this edge.
  - stall_in: hold q_out/valid_out; chk_pending<=0 (a held word is not rechecked).
  - Load: q_out<=d_in, valid_out<=valid_in, chk_pending<=1.
  - error_out<=0 on every edge except the mis edge.
- RECOVER:
  - d_in, valid_in and d_late are ignored; no compare is performed.
  - Counter decrements each edge.
  - When the counter is 1 at an edge: stall_out<=0, FSM<=NORMAL. stall_out is therefore high for exactly RECOVER_CYCLES cycles.
  - flush_in in RECOVER clears q_out/valid_out; the recovery window still runs to completion.
  - stall_in has no extra effect in RECOVER.
- Latency:
  - d_in to q_out: 1 cycle.
  - Error pulse: 1 cycle after the mismatch cycle, coincident with the corrected q_out.
- err_count: +1 on each mis edge; saturates at 2^CNT_W-1 and never wraps.
- Invalid words (valid_out=0) are never checked.
- Reset mid-RECOVER aborts recovery immediately (stall_out=0 the next cycle).

Optional Feature:
RAZOR_ERR_COUNT_EN
- Defined: err_count behaves as above.
- Undefined: no counter flops; err_count tied to 0. All other behaviour is identical.

Decomposition:
- Package razor_pkg: state typedef {NORMAL, RECOVER}; localparam defaults for WIDTH, RECOVER_CYCLES, CNT_W.
- Natural sub-module: razor_recover_fsm. It owns the state, recovery counter and stall_out; inputs mis, reset; output stall_out / in_recover.
- The data path and compare stay in razor_pipe_reg.

Test Plan:
- Reset, then load d_in=0x0000_0040_2002_0005, valid_in=1, d_late equal next cycle -> q_out equals word after 1 cycle; error_out=0; err_count=0.
- Load 0x...0005, next cycle d_late=0x...0004 -> following edge q_out=0x...0004, error_out=1 for one cycle, stall_out=1 for 1 cycle (RECOVER_CYCLES=1), err_count=1.
- RECOVER_CYCLES=3, mismatch -> stall_out high exactly 3 cycles; d_in changes during that window do not reach q_out.
- Mismatch cycle with flush_in=1 -> q_out=0, valid_out=0, error_out stays 0, err_count unchanged. Separately, stall_in=1 with matching d_late for 4 cycles -> q_out held, no error.
- CNT_W=2, 5 injected mismatches -> err_count reads 1,2,3,3,3. With RAZOR_ERR_COUNT_EN undefined -> err_count always 0.
- Reset asserted in 2nd cycle of a 3-cycle recovery -> next cycle stall_out=0, q_out=0, valid_out=0, FSM NORMAL.

Source files
------------

// File: rtl/razor_pkg.sv
// Shared types and default parameters for the Razor pipeline stage register.
package razor_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } razor_state_e;

    localparam int DEF_WIDTH          = 64;
    localparam int DEF_RECOVER_CYCLES = 1;
    localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/razor_recover_fsm.sv
// Recovery sequencer: on a detected mismatch, holds stall_out high for
// exactly RECOVER_CYCLES cycles, then returns to NORMAL.
module razor_recover_fsm
    import razor_pkg::*;
#(
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic mis,
    output logic stall_out,
    output logic in_recover
);

    localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

    razor_state_e    state_q, state_d;
    logic [RC_W-1:0] cnt_q, cnt_d;
    logic            stall_q, stall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        case (state_q)
            NORMAL: begin
                if (mis) begin
                    state_d = RECOVER;
                    cnt_d   = RC_W'(RECOVER_CYCLES);
                    stall_d = 1'b1;
                end
            end
            RECOVER: begin
                cnt_d = cnt_q - RC_W'(1);
                if (cnt_q == RC_W'(1)) begin
                    state_d = NORMAL;
                    stall_d = 1'b0;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_out  = stall_q;
    assign in_recover = (state_q == RECOVER);

endmodule

// File: rtl/razor_pipe_reg.sv
// Razor-style pipeline stage register with shadow-compare correction.
// Define RAZOR_ERR_COUNT_EN to build the saturating corrected-error counter.
module razor_pipe_reg
    import razor_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] d_late,
    output logic             valid_out,
    output logic [WIDTH-1:0] q_out,
    output logic             error_out,
    output logic             stall_out,
    output logic [CNT_W-1:0] err_count
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             chk_pending_q, chk_pending_d;
    logic             error_q, error_d;
    logic             in_recover;
    logic             mis;

    // A flush on the mismatch edge swallows the error entirely.
    assign mis = chk_pending_q & valid_q & (d_late != q_q) & ~in_recover & ~flush_in;

    razor_recover_fsm #(
        .RECOVER_CYCLES(RECOVER_CYCLES)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .mis       (mis),
        .stall_out (stall_out),
        .in_recover(in_recover)
    );

    always_comb begin
        q_d           = q_q;
        valid_d       = valid_q;
        chk_pending_d = 1'b0;
        error_d       = 1'b0;
        if (flush_in) begin
            q_d     = '0;
            valid_d = 1'b0;
        end else if (in_recover) begin
            // inputs are ignored until the recovery window closes
        end else if (mis) begin
            q_d     = d_late;
            error_d = 1'b1;
        end else if (!stall_in) begin
            q_d           = d_in;
            valid_d       = valid_in;
            chk_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q           <= '0;
            valid_q       <= 1'b0;
            chk_pending_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            q_q           <= q_d;
            valid_q       <= valid_d;
            chk_pending_q <= chk_pending_d;
            error_q       <= error_d;
        end
    end

`ifdef RAZOR_ERR_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (mis && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign err_count = cnt_q;
`else
    assign err_count = '0;
`endif

    assign q_out     = q_q;
    assign valid_out = valid_q;
    assign error_out = error_q;

endmodule

// File: tb/tb_razor_pipe_reg.sv
// Randomized + directed bench for razor_pipe_reg: two instances (1-cycle and
// 3-cycle recovery) checked against a per-instance behavioural model.
module tb_razor_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush_in, valid_in;
    logic [63:0] d_in, d_late_a, d_late_b;
    logic        valid_a, valid_b, err_a, err_b, stall_a, stall_b;
    logic [63:0] q_a, q_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    razor_pipe_reg #(.WIDTH(64), .RECOVER_CYCLES(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(valid_in), .d_in(d_in), .d_late(d_late_a),
        .valid_out(valid_a), .q_out(q_a), .error_out(err_a),
        .stall_out(stall_a), .err_count(cnt_a)
    );

    razor_pipe_reg #(.WIDTH(64), .RECOVER_CYCLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(valid_in), .d_in(d_in), .d_late(d_late_b),
        .valid_out(valid_b), .q_out(q_b), .error_out(err_b),
        .stall_out(stall_b), .err_count(cnt_b)
    );

    typedef struct {
        logic [63:0] q;
        bit          v;
        bit          pend;   // last edge loaded a new word
        bit          err;
        int          rec;    // stall cycles still owed
        int          cnt;    // corrected errors (saturating)
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.q = '0; m.v = 0; m.pend = 0; m.err = 0; m.rec = 0; m.cnt = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, bit rst, bit st, bit fl, bit vi,
                                  logic [63:0] di, logic [63:0] dl, int rc, int cmax);
        mdl_t n = m;
        if (rst) return mdl_reset();
        n.err  = 0;
        n.pend = 0;
        if (m.rec > 0) begin
            n.rec = m.rec - 1;
            if (fl) begin n.q = '0; n.v = 0; end
            return n;
        end
        if (fl) begin
            n.q = '0; n.v = 0;
        end else if (m.pend && m.v && (dl != m.q)) begin
            n.q   = dl;
            n.err = 1;
            n.rec = rc;
            if (m.cnt < cmax) n.cnt = m.cnt + 1;
        end else if (!st) begin
            n.q = di; n.v = vi; n.pend = 1;
        end
        return n;
    endfunction

    function automatic logic [63:0] exp_cnt(mdl_t m);
`ifdef RAZOR_ERR_COUNT_EN
        return 64'(m.cnt);
`else
        return 64'(0 * m.cnt);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("q_a",     q_a,            ma.q);
        check("valid_a", 64'(valid_a),   64'(ma.v));
        check("err_a",   64'(err_a),     64'(ma.err));
        check("stall_a", 64'(stall_a),   64'(ma.rec != 0));
        check("cnt_a",   64'(cnt_a),     exp_cnt(ma));
        check("q_b",     q_b,            mb.q);
        check("valid_b", 64'(valid_b),   64'(mb.v));
        check("err_b",   64'(err_b),     64'(mb.err));
        check("stall_b", 64'(stall_b),   64'(mb.rec != 0));
        check("cnt_b",   64'(cnt_b),     exp_cnt(mb));
    endtask

    // One clock: drive inputs, d_late = expected held word XOR flip mask.
    task automatic cyc(input bit rst, input bit st, input bit fl, input bit vi,
                       input logic [63:0] di, input logic [63:0] fa, input logic [63:0] fb);
        mdl_t na, nb;
        reset    = rst;
        stall_in = st;
        flush_in = fl;
        valid_in = vi;
        d_in     = di;
        d_late_a = ma.q ^ fa;
        d_late_b = mb.q ^ fb;
        na = step(ma, rst, st, fl, vi, di, d_late_a, 1, 255);
        nb = step(mb, rst, st, fl, vi, di, d_late_b, 3, 3);
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
        check_all();
    endtask

    localparam logic [63:0] W5 = 64'h0000_0040_2002_0005;

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();
        reset = 1; stall_in = 0; flush_in = 0; valid_in = 0;
        d_in = '0; d_late_a = '0; d_late_b = '0;

        // reset state
        cyc(1, 0, 0, 0, 64'h0, 0, 0);
        cyc(1, 0, 0, 0, 64'h0, 0, 0);

        // clean load then matching shadow
        cyc(0, 0, 0, 1, W5, 0, 0);
        cyc(0, 0, 0, 1, 64'h1111, 0, 0);

        // load W5 then shadow differs in bit 0 -> corrected to ...0004
        cyc(0, 0, 0, 1, W5, 0, 0);
        cyc(0, 0, 0, 1, 64'hdead, 64'h1, 64'h1);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 1, {$urandom, $urandom}, 0, 0);

        // mismatch coincident with flush: bubble, no error
        cyc(0, 0, 0, 1, W5, 0, 0);
        cyc(0, 0, 1, 1, 64'h77, 64'h4, 64'h4);

        // stall with matching shadow for 4 cycles
        cyc(0, 0, 0, 1, W5, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 0, 1, {$urandom, $urandom}, 0, 0);

        // five mismatches -> saturation of the narrow counter
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1, {$urandom, $urandom}, 0, 0);
            cyc(0, 0, 0, 1, 64'h5, 64'h100, 64'h100);
            for (int i = 0; i < 3; i++)
                cyc(0, 0, 0, 1, {$urandom, $urandom}, 0, 0);
        end

        // reset during the second cycle of a 3-cycle recovery
        cyc(0, 0, 0, 1, W5, 0, 0);
        cyc(0, 0, 0, 1, 64'h9, 64'h2, 64'h2);
        cyc(0, 0, 0, 1, 64'ha, 0, 0);
        cyc(1, 0, 0, 1, 64'hb, 0, 0);
        cyc(0, 0, 0, 1, W5, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] fa, fb;
            fa = ($urandom_range(3) == 0) ? (64'h1 << $urandom_range(63)) : 64'h0;
            fb = ($urandom_range(3) == 0) ? (64'h1 << $urandom_range(63)) : 64'h0;
            cyc($urandom_range(99) == 0, $urandom_range(4) == 0,
                $urandom_range(9) == 0, $urandom_range(3) != 0,
                {$urandom, $urandom}, fa, fb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
